// File: rtl/seq_detector_param.sv
// Runtime-configurable Mealy serial-pattern detector with overlap control,
// input-valid qualifier, registered match copy and saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_1001),
  parameter int                 DEFAULT_LEN = 4,
  parameter logic               DEFAULT_OVL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         x,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pat,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_ovl,
  input  logic                         cnt_clr,
  output logic                         z,
  output logic                         z_q,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int               LW        = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]    MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // The oldest history bit can never reach a window of at most MAX_LEN bits,
  // so only MAX_LEN-1 bits are stored.
  logic [MAX_LEN-2:0] hist_r;
  logic [LW-1:0]      fill_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  logic               z_q_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               len_ok_s;
  logic               z_s;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == {LW{1'b0}}) begin
      return LW'(1'b1);
    end else if (l > MAX_LEN_L) begin
      return MAX_LEN_L;
    end else begin
      return l;
    end
  endfunction

  // Window of the newest len_r bits and the zero-latency match decision.
  always_comb begin
    window_s = {hist_r, x};
    mask_s   = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LW'(i) < len_r);
    end
    len_ok_s = (({1'b0, fill_r} + (LW + 1)'(1'b1)) >= {1'b0, len_r});
    z_s      = rst & en & ~cfg_load & len_ok_s &
               ((window_s & mask_s) == (pat_r & mask_s));
  end

  // Configuration latch, shift history and valid-bit fill level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LW{1'b0}};
      pat_r  <= DEFAULT_PAT;
      len_r  <= LW'(DEFAULT_LEN);
      ovl_r  <= DEFAULT_OVL;
    end else if (cfg_load) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LW{1'b0}};
      pat_r  <= cfg_pat;
      len_r  <= clamp_len(cfg_len);
      ovl_r  <= cfg_ovl;
    end else if (en) begin
      hist_r <= window_s[MAX_LEN-2:0];
      if (z_s && !ovl_r) begin
        fill_r <= {LW{1'b0}};
      end else if (fill_r != MAX_LEN_L) begin
        fill_r <= fill_r + LW'(1'b1);
      end else begin
        fill_r <= fill_r;
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Registered match copy and saturating match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_q_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      z_q_r <= z_s;
      if (cnt_clr) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (z_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign z         = z_s;
  assign z_q       = z_q_r;
  assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       x;
  logic       cfg_load;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_ovl;
  logic       cnt_clr;
  logic       z, z_q, z2, z_q2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int errors = 0;
  int checks = 0;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .z(z), .z_q(z_q), .match_cnt(match_cnt)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .z(z2), .z_q(z_q2), .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted bits since the last restart point, oldest first.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt8, m_cnt2;
  bit         m_zq;

  function automatic void model_reset();
    mq.delete();
    m_pat  = 8'b0000_1001;
    m_len  = 4;
    m_ovl  = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_zq   = 1'b0;
  endfunction

  // A match: enough accepted bits, and the newest m_len bits (x newest)
  // read oldest-first equal pattern bits [m_len-1] down to [0].
  function automatic bit exp_z();
    bit b;
    if (rst !== 1'b1 || en !== 1'b1 || cfg_load !== 1'b0) return 1'b0;
    if (mq.size() + 1 < m_len) return 1'b0;
    for (int age = 0; age < m_len; age++) begin
      b = (age == 0) ? x : mq[mq.size() - age];
      if (b != m_pat[age]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge rst) model_reset();

  // Per-cycle compare, then advance the model to the coming rising edge.
  always @(negedge clk) begin
    bit zc;
    int l;
    zc = exp_z();
    chk("z", {31'd0, z}, {31'd0, zc});
    chk("z_w2", {31'd0, z2}, {31'd0, zc});
    chk("z_q", {31'd0, z_q}, {31'd0, m_zq});
    chk("z_q_w2", {31'd0, z_q2}, {31'd0, m_zq});
    chk("match_cnt", {24'd0, match_cnt}, m_cnt8);
    chk("match_cnt_w2", {30'd0, match_cnt2}, m_cnt2);
    if (rst === 1'b1) begin
      m_zq = zc;
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (zc) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (cfg_load) begin
        l = int'(cfg_len);
        if (l == 0) l = 1;
        if (l > 8) l = 8;
        m_pat = cfg_pat;
        m_len = l;
        m_ovl = cfg_ovl;
        mq.delete();
      end else if (en) begin
        if (zc && !m_ovl) begin
          mq.delete();
        end else begin
          mq.push_back(x);
          if (mq.size() > 8) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit e, input bit b, input bit ld, input bit clr, output bit zo);
    en = e; x = b; cfg_load = ld; cnt_clr = clr;
    @(negedge clk);
    zo = z;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    bit d;
    cfg_pat = p; cfg_len = l; cfg_ovl = o;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic clear_cnt();
    bit d;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  // Bits are given first-received at position n-1; hits[i] is z on the i-th bit.
  task automatic feed(input logic [31:0] bits, input int n, output logic [31:0] hits);
    bit zb;
    hits = 32'd0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, bits[n-1-i], 1'b0, 1'b0, zb);
      hits[i] = zb;
    end
  endtask

  task automatic rst_pulse(input bit lit);
    en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    if (lit) begin
      chk("rst_z", {31'd0, z}, 32'd0);
      chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hits;
    bit zo, gz;
    logic [7:0] p3;
    int r;
    model_reset();
    rst = 1'b0; en = 1'b0; x = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pat = 8'd0; cfg_len = 4'd0; cfg_ovl = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_z_q", {31'd0, z_q}, 32'd0);
    chk("reset_cnt", {24'd0, match_cnt}, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Defaults, non-overlapping
    feed(32'b100100100100111011, 18, hits);
    chk("s1_hits", hits, 32'h0000_0208);
    chk("s1_cnt", {24'd0, match_cnt}, 32'd2);

    // Overlapping
    load(8'b0000_1001, 4'd4, 1'b1);
    clear_cnt();
    feed(32'b100100100100111011, 18, hits);
    chk("s2_hits", hits, 32'h0000_1248);
    chk("s2_cnt", {24'd0, match_cnt}, 32'd4);

    // Full length with en gaps
    p3 = 8'b1011_0110;
    load(p3, 4'd8, 1'b0);
    clear_cnt();
    hits = 32'd0;
    gz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, p3[7-i], 1'b0, 1'b0, zo);
      hits[i] = zo;
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, zo);
      gz |= zo;
    end
    chk("s3_hits", hits, 32'h0000_0080);
    chk("s3_gap_z", {31'd0, gz}, 32'd0);

    // Length clamping
    load(8'b0000_0001, 4'd0, 1'b0);
    feed(32'b1101, 4, hits);
    chk("s4_len0", hits, 32'h0000_000B);
    load(8'b1011_0110, 4'd15, 1'b0);
    feed(32'b1110110110, 10, hits);
    chk("s4_len15", hits, 32'h0000_0200);

    // Config load on a matching bit
    load(8'b0000_1001, 4'd4, 1'b0);
    clear_cnt();
    feed(32'b100, 3, hits);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, zo);
    chk("s5_load_z", {31'd0, zo}, 32'd0);
    chk("s5_load_cnt", {24'd0, match_cnt}, 32'd0);
    feed(32'b001001, 6, hits);
    chk("s5_after_load", hits, 32'h0000_0020);

    // Counter saturation and clear priority
    load(8'b0000_0001, 4'd1, 1'b0);
    clear_cnt();
    feed(32'b11111, 5, hits);
    chk("s5_cnt8", {24'd0, match_cnt}, 32'd5);
    chk("s5_cnt2_sat", {30'd0, match_cnt2}, 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, zo);
    chk("s5_clr_z", {31'd0, zo}, 32'd1);
    chk("s5_clr_cnt", {24'd0, match_cnt}, 32'd0);

    // Reset mid-pattern restores defaults and empties history
    load(8'b0000_0110, 4'd4, 1'b1);
    feed(32'b100, 3, hits);
    rst_pulse(1'b1);
    feed(32'b1001001, 7, hits);
    chk("s6_hits", hits, 32'h0000_0008);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        rst_pulse(1'b0);
      end else if (r < 5) begin
        cfg_pat = 8'($urandom);
        cfg_len = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
        cfg_ovl = 1'($urandom_range(0, 1));
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
            ($urandom_range(0, 9) == 0), zo);
      end else begin
        cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
            ($urandom_range(0, 49) == 0), zo);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
